// File: rtl/alarm_ring_ctrl_pkg.sv
// alarm_ring_ctrl_pkg: shared state encoding, service indices and BCD mmss field offsets
package alarm_ring_ctrl_pkg;
    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } ring_state_t;
    localparam int CLK_SET   = 0;
    localparam int ALM_SET   = 1;
    localparam int STOPWATCH = 2;
    localparam int SEC_LO    = 0;
    localparam int SEC_HI    = 4;
    localparam int MIN_LO    = 8;
    localparam int MIN_HI    = 12;
endpackage

// File: rtl/alarm_ring_ctrl_svc_arbiter.sv
// svc_arbiter: switch-to-grant ownership of buttons/display, with a one-cycle idle gap on release
module svc_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] grant
);
    logic [2:0] grant_next;
    // idle picks the lowest set switch; an owner keeps its grant until its own switch drops
    always_comb
        grant_next = (grant == 3'b000) ? (req & (~req + 3'd1)) :
                     ((grant & req) != 3'b000) ? grant : 3'b000;
    always_ff @(posedge clk)
        if (reset) grant <= 3'b000;
        else       grant <= grant_next;
endmodule

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: service arbitration plus the arm/ring/snooze/disarm alarm state machine
module alarm_ring_ctrl
    import alarm_ring_ctrl_pkg::*;
#(
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spdt1,
    input  logic        spdt2,
    input  logic        spdt3,
    input  logic        push_u,
    input  logic        push_d,
    input  logic        push_l,
    input  logic        push_r,
    input  logic        tick_1hz,
    input  logic [15:0] cur_time,
    input  logic [15:0] alarm,
    input  logic        alarm_done,
    output logic [2:0]  grant,
    output logic        armed,
    output logic        ringing,
    output logic        buzz,
    output logic [6:0]  ring_left
);
    localparam logic [6:0] RING_LOAD   = 7'(RING_SEC);
    localparam logic [6:0] SNOOZE_LOAD = 7'(SNOOZE_SEC);
    localparam logic [2:0] ALM_GRANT   = 3'(1 << ALM_SET);

    ring_state_t state, state_next;
    logic [6:0]  ring_left_next;
    logic        buzz_next, btn_free, up, dn, match, last, unused_lr;

    svc_arbiter u_arb (
        .clk  (clk),
        .reset(reset),
        .req  ({spdt3, spdt2, spdt1}),
        .grant(grant)
    );

    assign btn_free  = grant == 3'b000;
    assign up        = push_u & btn_free;
    assign dn        = push_d & btn_free;
    assign match     = cur_time == alarm;
    assign last      = ring_left == 7'd1;
    assign unused_lr = push_l | push_r;

    always_ff @(posedge clk)
        if (reset) begin
            state     <= DISARMED;
            ring_left <= 7'd0;
            buzz      <= 1'b0;
        end else begin
            state     <= state_next;
            ring_left <= ring_left_next;
            buzz      <= buzz_next;
        end

    // push_d disarms from any armed state, so it also pre-empts a same-cycle match
    always_comb
        state_next = (grant == ALM_GRANT)                         ? DISARMED :
                     (dn)                                         ? DISARMED :
                     (up && state == RINGING)                     ? SNOOZE   :
                     (tick_1hz && state == ARMED && match)        ? RINGING  :
                     (tick_1hz && state == RINGING && last)       ? ARMED    :
                     (tick_1hz && state == SNOOZE && last)        ? RINGING  :
                     (alarm_done && state == DISARMED)            ? ARMED    : state;

    always_comb begin
        ring_left_next = (state_next == RINGING) ? ((state != RINGING) ? RING_LOAD : ring_left - {6'd0, tick_1hz}) :
                         (state_next == SNOOZE)  ? ((state != SNOOZE) ? SNOOZE_LOAD : ring_left - {6'd0, tick_1hz}) :
                         7'd0;
        buzz_next      = (state_next == RINGING) && ((state != RINGING) || (buzz ^ tick_1hz));
        armed          = state != DISARMED;
        ringing        = state == RINGING;
    end
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_alarm_ring_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic        spdt1 = 0, spdt2 = 0, spdt3 = 0;
    logic        push_u = 0, push_d = 0, push_l = 0, push_r = 0;
    logic        tick_1hz = 0, alarm_done = 0;
    logic [15:0] cur_time = 16'h0000, alarm = 16'h0105;
    logic [2:0]  grant;
    logic        armed, ringing, buzz;
    logic [6:0]  ring_left;

    typedef struct {
        string      name;
        logic [2:0] g;
        logic       a;
        logic       r;
        logic       b;
        logic [6:0] rl;
    } exp_t;

    exp_t q[$];
    int   errors = 0, checks = 0;

    alarm_ring_ctrl dut (
        .clk(clk), .reset(reset),
        .spdt1(spdt1), .spdt2(spdt2), .spdt3(spdt3),
        .push_u(push_u), .push_d(push_d), .push_l(push_l), .push_r(push_r),
        .tick_1hz(tick_1hz), .cur_time(cur_time), .alarm(alarm), .alarm_done(alarm_done),
        .grant(grant), .armed(armed), .ringing(ringing), .buzz(buzz), .ring_left(ring_left)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({grant, armed, ringing, buzz, ring_left} !== {e.g, e.a, e.r, e.b, e.rl}) begin
                errors++;
                $display("FAIL %s: got grant=%b armed=%b ringing=%b buzz=%b ring_left=%0d, need grant=%b armed=%b ringing=%b buzz=%b ring_left=%0d",
                         e.name, grant, armed, ringing, buzz, ring_left, e.g, e.a, e.r, e.b, e.rl);
            end
        end

    task automatic clk1();
        @(posedge clk);
        #1;
        push_u = 0; push_d = 0; tick_1hz = 0; alarm_done = 0;
    endtask

    task automatic expect_out(input string name, input logic [2:0] g, input logic a, input logic r,
                              input logic b, input logic [6:0] rl);
        exp_t e;
        e.name = name; e.g = g; e.a = a; e.r = r; e.b = b; e.rl = rl;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clk1(); expect_out("reset", 3'b000, 0, 0, 0, 7'd0);
        reset = 0;
        // arbitration: simultaneous request, hold, release gap, re-arbitrate
        spdt2 = 1; spdt3 = 1;
        clk1(); expect_out("arb_lowest", 3'b010, 0, 0, 0, 7'd0);
        clk1(); expect_out("arb_hold", 3'b010, 0, 0, 0, 7'd0);
        spdt2 = 0;
        clk1(); expect_out("arb_gap", 3'b000, 0, 0, 0, 7'd0);
        clk1(); expect_out("arb_regrant", 3'b100, 0, 0, 0, 7'd0);
        spdt3 = 0;
        clk1(); expect_out("arb_release", 3'b000, 0, 0, 0, 7'd0);
        // arm, non-matching tick, matching tick, full ring
        alarm_done = 1;
        clk1(); expect_out("arm", 3'b000, 1, 0, 0, 7'd0);
        cur_time = 16'h0104; tick_1hz = 1;
        clk1(); expect_out("no_match", 3'b000, 1, 0, 0, 7'd0);
        cur_time = 16'h0105; tick_1hz = 1;
        clk1(); expect_out("ring_start", 3'b000, 1, 1, 1, 7'd30);
        cur_time = 16'h0106;
        for (int k = 1; k < 30; k++) begin
            tick_1hz = 1;
            clk1(); expect_out("ring_count", 3'b000, 1, 1, (k % 2 == 0), 7'(30 - k));
        end
        tick_1hz = 1;
        clk1(); expect_out("ring_end", 3'b000, 1, 0, 0, 7'd0);
        // re-fire, snooze, snooze expiry
        cur_time = 16'h0105; tick_1hz = 1;
        clk1(); expect_out("refire", 3'b000, 1, 1, 1, 7'd30);
        cur_time = 16'h0106; push_u = 1;
        clk1(); expect_out("snooze", 3'b000, 1, 0, 0, 7'd60);
        for (int k = 1; k < 60; k++) begin
            tick_1hz = 1;
            clk1(); expect_out("snooze_count", 3'b000, 1, 0, 0, 7'(60 - k));
        end
        tick_1hz = 1;
        clk1(); expect_out("snooze_end", 3'b000, 1, 1, 1, 7'd30);
        // buttons owned by clock-set are ignored
        spdt1 = 1;
        clk1(); expect_out("grant_clk", 3'b001, 1, 1, 1, 7'd30);
        push_u = 1;
        clk1(); expect_out("push_u_gated", 3'b001, 1, 1, 1, 7'd30);
        spdt1 = 0;
        clk1(); expect_out("clk_release", 3'b000, 1, 1, 1, 7'd30);
        push_d = 1;
        clk1(); expect_out("push_d_disarm", 3'b000, 0, 0, 0, 7'd0);
        // alarm-set ownership disarms from SNOOZE
        alarm_done = 1;
        clk1(); expect_out("rearm", 3'b000, 1, 0, 0, 7'd0);
        cur_time = 16'h0105; tick_1hz = 1;
        clk1(); expect_out("ring2", 3'b000, 1, 1, 1, 7'd30);
        cur_time = 16'h0106; push_u = 1;
        clk1(); expect_out("snooze2", 3'b000, 1, 0, 0, 7'd60);
        spdt2 = 1;
        clk1(); expect_out("alm_grant", 3'b010, 1, 0, 0, 7'd60);
        clk1(); expect_out("alm_disarm", 3'b010, 0, 0, 0, 7'd0);
        spdt2 = 0;
        clk1(); expect_out("alm_release", 3'b000, 0, 0, 0, 7'd0);
        cur_time = 16'h0105; tick_1hz = 1;
        clk1(); expect_out("disarmed_no_ring", 3'b000, 0, 0, 0, 7'd0);
        alarm_done = 1;
        clk1(); expect_out("rearm2", 3'b000, 1, 0, 0, 7'd0);
        // priority: push_d beats matching tick and alarm_done
        tick_1hz = 1; push_d = 1; alarm_done = 1;
        clk1(); expect_out("prio_push_d", 3'b000, 0, 0, 0, 7'd0);
        // reset mid-ring
        alarm_done = 1;
        clk1(); expect_out("rearm3", 3'b000, 1, 0, 0, 7'd0);
        tick_1hz = 1;
        clk1(); expect_out("ring3", 3'b000, 1, 1, 1, 7'd30);
        tick_1hz = 1;
        clk1(); expect_out("ring3_tick", 3'b000, 1, 1, 0, 7'd29);
        reset = 1;
        clk1(); expect_out("reset_mid_ring", 3'b000, 0, 0, 0, 7'd0);
        reset = 0; tick_1hz = 1;
        clk1(); expect_out("post_reset_idle", 3'b000, 0, 0, 0, 7'd0);
        // alarm 00:00 is a legal match
        alarm = 16'h0000; cur_time = 16'h0000; alarm_done = 1;
        clk1(); expect_out("arm_zero", 3'b000, 1, 0, 0, 7'd0);
        tick_1hz = 1;
        clk1(); expect_out("ring_zero", 3'b000, 1, 1, 1, 7'd30);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL drain: got %0d unchecked entries, need 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
